// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler: round-robin sharing of the 7-seg displays between requesters
// with a minimum hold time in prescaler ticks and a blank frame between owners.
module hex_display_scheduler #(
  parameter int NUM_REQ    = 3,
  parameter int DIGITS     = 6,
  parameter int TICK_DIV   = 25000000,
  parameter int HOLD_TICKS = 2
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET_N,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DIGITS*4-1:0]   req_data,
  input  logic [NUM_REQ*DIGITS-1:0]     req_mask,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic [DIGITS*7-1:0]           hex_out
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  typedef enum logic [1:0] {IDLE, OWN, HANDOFF} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, rr_q, rr_d, win;
  logic [PW-1:0] pre_q;
  logic [HW-1:0] hold_q, hold_d;
  logic [DIGITS*7-1:0] hex_q, hex_d;
  logic [NUM_REQ-1:0] own_oh;
  logic tick, found, own_req, others;
  int j;
  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction
  assign tick    = pre_q == PW'(TICK_DIV - 1);
  assign own_oh  = NUM_REQ'(1) << owner_q;
  assign own_req = |(req & own_oh);
  assign others  = |(req & ~own_oh);
  assign busy    = state_q == OWN;
  assign grant   = busy ? own_oh : '0;
  assign hex_out = hex_q;
  // First requester at or after rr_q, searching modulo NUM_REQ
  always_comb begin
    win = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        win = IW'(j);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = OWN;
        owner_d = win;
        hold_d  = '0;
      end
      OWN: begin
        hold_d = (tick && hold_q != HW'(HOLD_TICKS)) ? hold_q + 1'b1 : hold_q;
        state_d = (!own_req || (hold_q == HW'(HOLD_TICKS) && others)) ? HANDOFF : OWN;
      end
      HANDOFF: begin
        state_d = IDLE;
        rr_d = owner_q == IW'(NUM_REQ - 1) ? '0 : owner_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    hex_d = '0;
    for (int d = 0; d < DIGITS; d++)
      hex_d[d*7 +: 7] = (busy && req_mask[int'(owner_q)*DIGITS + d])
                        ? seg(req_data[int'(owner_q)*DIGITS*4 + d*4 +: 4]) : 7'h7F;
  end
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      pre_q   <= '0;
      hold_q  <= '0;
      hex_q   <= {DIGITS{7'h7F}};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      pre_q   <= tick ? '0 : pre_q + 1'b1;
      hold_q  <= hold_d;
      hex_q   <= hex_d;
    end
  end
endmodule

// File: tb/tb_hex_display_scheduler.sv
// tb_hex_display_scheduler: directed scenarios plus random traffic checked every cycle
// against an integer-level model of ownership, hold ticks and the displayed frame.
module tb_hex_display_scheduler;
  localparam int NR = 3, DG = 6, TD = 4, HT = 2;
  localparam logic [DG*7-1:0] BLANK = {DG{7'h7F}};
  logic CLOCK_50 = 0, RESET_N = 0;
  logic [NR-1:0] req = '0;
  logic [NR*DG*4-1:0] req_data = '0;
  logic [NR*DG-1:0] req_mask = '0;
  logic [NR-1:0] grant;
  logic busy;
  logic [DG*7-1:0] hex_out;
  int total = 0, bad = 0;
  int m_own, m_ho, m_last, m_rr, m_hold, m_pre;
  logic [DG*7-1:0] m_hex;
  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [NR-1:0] seq [$];
  hex_display_scheduler #(.NUM_REQ(NR), .DIGITS(DG), .TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .req(req), .req_data(req_data),
    .req_mask(req_mask), .grant(grant), .busy(busy), .hex_out(hex_out));
  always #5 CLOCK_50 = ~CLOCK_50;
  function automatic logic [DG*7-1:0] frame(int o);
    logic [DG*7-1:0] f;
    logic [3:0] n;
    for (int d = 0; d < DG; d++) begin
      n = req_data[o*DG*4 + d*4 +: 4];
      f[d*7 +: 7] = req_mask[o*DG + d] ? dec[n] : 7'h7F;
    end
    return f;
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset;
    m_own = -1; m_ho = 0; m_last = 0; m_rr = 0; m_hold = 0; m_pre = 0; m_hex = BLANK;
  endtask
  task automatic model_edge;
    logic tk;
    int w;
    m_hex = m_own >= 0 ? frame(m_own) : BLANK;
    tk = m_pre == TD - 1;
    m_pre = (m_pre + 1) % TD;
    if (m_own >= 0) begin
      if (!req[m_own] || (m_hold == HT && (req & ~(NR'(1) << m_own)) != 0)) begin
        m_last = m_own; m_own = -1; m_ho = 1;
      end else if (tk && m_hold < HT) m_hold++;
    end else if (m_ho != 0) begin
      m_ho = 0; m_rr = (m_last + 1) % NR;
    end else begin
      w = -1;
      for (int k = 0; k < NR; k++)
        if (w < 0 && req[(m_rr + k) % NR]) w = (m_rr + k) % NR;
      if (w >= 0) begin m_own = w; m_hold = 0; end
    end
  endtask
  task automatic step;
    logic [NR-1:0] eg;
    @(posedge CLOCK_50);
    model_edge();
    @(negedge CLOCK_50);
    eg = m_own >= 0 ? NR'(1) << m_own : '0;
    chk("grant", grant, eg);
    chk("busy", busy, m_own >= 0);
    chk("hex", hex_out, m_hex);
  endtask
  task automatic rst_pulse;
    #2 RESET_N = 0;
    #1;
    chk("async_rst grant", grant, 0);
    chk("async_rst busy", busy, 0);
    chk("async_rst hex", hex_out, BLANK);
    model_reset();
    @(negedge CLOCK_50);
    RESET_N = 1;
  endtask
  initial begin
    logic [NR-1:0] prev;
    int len, gap;
    model_reset();
    repeat (2) @(negedge CLOCK_50);
    chk("reset grant", grant, 0);
    chk("reset busy", busy, 0);
    chk("reset hex", hex_out, BLANK);
    RESET_N = 1;
    req = 3'b010;
    req_data[DG*4 +: DG*4] = 24'h543210;
    req_mask[DG +: DG] = 6'h3F;
    step();
    chk("single grant", grant, 3'b010);
    step();
    chk("single hex", hex_out, {7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40});
    repeat (20) step();
    chk("single held", grant, 3'b010);
    req_mask[DG +: DG] = 6'b000011;
    step();
    chk("mask hex", hex_out, {{4{7'h7F}}, 7'h79, 7'h40});
    rst_pulse();
    req = 3'b111;
    prev = '0; len = 0; gap = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (grant != 0) begin
        if (prev == 0 && seq.size() > 0) chk("rr gap", gap, 2);
        if (grant != prev) seq.push_back(grant);
        len++; gap = 0;
      end else begin
        if (prev != 0) begin
          chk("rr len ok", len <= 9 && len >= 1, 1);
          len = 0;
        end
        gap++;
      end
      prev = grant;
    end
    chk("rr count", seq.size() >= 4, 1);
    chk("rr seq0", seq[0], 3'b001);
    chk("rr seq1", seq[1], 3'b010);
    chk("rr seq2", seq[2], 3'b100);
    chk("rr seq3", seq[3], 3'b001);
    rst_pulse();
    req = 3'b011;
    step();
    chk("drop own", grant, 3'b001);
    req = 3'b010;
    step();
    chk("drop handoff", grant, 3'b000);
    step();
    chk("drop idle", grant, 3'b000);
    step();
    chk("drop next", grant, 3'b010);
    rst_pulse();
    req = 3'b100;
    step();
    chk("wrap own2", grant, 3'b100);
    req = 3'b001;
    repeat (3) step();
    chk("wrap own0", grant, 3'b001);
    rst_pulse();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) req = req ^ (NR'(1) << $urandom_range(NR - 1));
      req_data = {$urandom, $urandom, $urandom};
      req_mask = NR*DG'($urandom);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
